pc_sequencer: RTL and testbench

- Multicycle control FSM that sequences the program counter and instruction flow of the MIPS core.
- Holds instruction fetch until instruction memory is ready, then decodes the opcode and steps through EXEC, MEM and WB.
- Issues exactly one PC-advance strobe per retired instruction, together with the Branch/PcSel select codes the PC block consumes.
- Also counts retired instructions and traps memory-handshake timeouts.

---
 rtl/pc_sequencer.sv | 172 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Multicycle MIPS PC/instruction-flow sequencer: FETCH/DECODE/EXEC/MEM/WB with memory timeout trap.
// Optional macro PC_SEQ_ILLEGAL_TRAP_EN: unrecognised opcodes halt with Fault instead of retiring as NOP.
module pc_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             Clk,
    input  logic             ReSet_n,
    input  logic [5:0]       Opcode,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             IMemReady,
    input  logic             DMemReady,
    output logic             IMemReq,
    output logic             IrWrite,
    output logic             DMemReq,
    output logic             DMemWe,
    output logic             RegWrite,
    output logic             PcWrite,
    output logic [2:0]       Branch,
    output logic             PcSel,
    output logic [CNT_W-1:0] InstrCnt,
    output logic             Fault,
    output logic [2:0]       State
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [2:0] BR_SEQ  = 3'b000;
    localparam logic [2:0] BR_JUMP = 3'b011;
    localparam logic [2:0] BR_JR   = 3'b111;

    // Last wait index before timeout; ready on this cycle still wins.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [7:0]       wait_reg, wait_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             fault_reg;
    logic             fault_set;

    logic is_rtype, is_jr, is_wb_op, is_mem_op, is_sw;

    assign is_rtype  = (Opcode == OP_RTYPE);
    assign is_jr     = is_rtype && (Funct == FN_JR);
    assign is_wb_op  = (is_rtype && !is_jr) || (Opcode == OP_ADDIU) || (Opcode == OP_ORI)
                     || (Opcode == OP_LUI) || (Opcode == OP_JAL);
    assign is_mem_op = (Opcode == OP_LW) || (Opcode == OP_SW);
    assign is_sw     = (Opcode == OP_SW);

    always_comb begin
        state_next = state_reg;
        wait_next  = 8'd0;
        fault_set  = 1'b0;
        IMemReq    = 1'b0;
        IrWrite    = 1'b0;
        DMemReq    = 1'b0;
        DMemWe     = 1'b0;
        RegWrite   = 1'b0;
        PcWrite    = 1'b0;
        Branch     = BR_SEQ;
        PcSel      = 1'b0;
        case (state_reg)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH: begin
                IMemReq = 1'b1;
                if (IMemReady) begin
                    IrWrite    = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_reg == WAIT_LAST) begin
                    fault_set  = 1'b1;
                    state_next = S_HALT;
                end else begin
                    wait_next = wait_reg + 8'd1;
                end
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                if (is_jr) begin
                    PcWrite    = 1'b1;
                    Branch     = BR_JR;
                    state_next = S_FETCH;
                end else if (is_wb_op) begin
                    state_next = S_WB;
                end else if (is_mem_op) begin
                    state_next = S_MEM;
                end else if (Opcode == OP_BEQ) begin
                    PcWrite    = 1'b1;
                    PcSel      = Zero;
                    state_next = S_FETCH;
                end else if (Opcode == OP_J) begin
                    PcWrite    = 1'b1;
                    Branch     = BR_JUMP;
                    state_next = S_FETCH;
                end else begin
`ifdef PC_SEQ_ILLEGAL_TRAP_EN
                    fault_set  = 1'b1;
                    state_next = S_HALT;
`else
                    PcWrite    = 1'b1;
                    state_next = S_FETCH;
`endif
                end
            end
            S_MEM: begin
                DMemReq = 1'b1;
                DMemWe  = is_sw;
                if (DMemReady) begin
                    if (is_sw) begin
                        PcWrite    = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (wait_reg == WAIT_LAST) begin
                    fault_set  = 1'b1;
                    state_next = S_HALT;
                end else begin
                    wait_next = wait_reg + 8'd1;
                end
            end
            S_WB: begin
                RegWrite   = 1'b1;
                PcWrite    = 1'b1;
                Branch     = (Opcode == OP_JAL) ? BR_JUMP : BR_SEQ;
                state_next = S_FETCH;
            end
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge ReSet_n) begin
        if (!ReSet_n) begin
            state_reg <= S_IDLE;
            wait_reg  <= 8'd0;
            cnt_reg   <= '0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if (PcWrite)
                cnt_reg <= cnt_reg + CNT_W'(1);
            if (fault_set)
                fault_reg <= 1'b1;
        end
    end

    assign InstrCnt = cnt_reg;
    assign Fault    = fault_reg;
    assign State    = state_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: cycle table for the main instruction mix plus
// hand sequences for memory wait, timeout, ready-at-limit and async reset abort.
module tb_pc_sequencer;

    localparam int CNT_W = 32;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BAD   = 6'h3F;

    localparam logic [2:0] ST_I = 3'd0, ST_F = 3'd1, ST_D = 3'd2, ST_E = 3'd3,
                           ST_M = 3'd4, ST_W = 3'd5, ST_H = 3'd6;

    // Strobe bits: {IMemReq, IrWrite, DMemReq, DMemWe, RegWrite, PcWrite, PcSel}
    localparam logic [6:0] X_NONE = 7'b0000000;
    localparam logic [6:0] X_IMQ  = 7'b1000000;
    localparam logic [6:0] X_IRW  = 7'b0100000;
    localparam logic [6:0] X_DMQ  = 7'b0010000;
    localparam logic [6:0] X_DMW  = 7'b0001000;
    localparam logic [6:0] X_RW   = 7'b0000100;
    localparam logic [6:0] X_PCW  = 7'b0000010;
    localparam logic [6:0] X_PS   = 7'b0000001;

    logic             Clk = 1'b0;
    logic             ReSet_n = 1'b0;
    logic [5:0]       Opcode = '0;
    logic [5:0]       Funct = '0;
    logic             Zero = 1'b0;
    logic             IMemReady = 1'b0;
    logic             DMemReady = 1'b0;
    logic             IMemReq, IrWrite, DMemReq, DMemWe, RegWrite, PcWrite, PcSel, Fault;
    logic [2:0]       Branch, State;
    logic [CNT_W-1:0] InstrCnt;

    pc_sequencer #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .ReSet_n(ReSet_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .IMemReady(IMemReady), .DMemReady(DMemReady), .IMemReq(IMemReq), .IrWrite(IrWrite),
        .DMemReq(DMemReq), .DMemWe(DMemWe), .RegWrite(RegWrite), .PcWrite(PcWrite),
        .Branch(Branch), .PcSel(PcSel), .InstrCnt(InstrCnt), .Fault(Fault), .State(State)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       zero;
        logic       dmr;
        logic [2:0] st;
        logic [6:0] strb;
        logic [2:0] br;
        logic       flt;
        int         cnt;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;
    int   n_pcw, n_dmq, n_dmw, n_cyc;
    logic [6:0] act_strb;

    assign act_strb = {IMemReq, IrWrite, DMemReq, DMemWe, RegWrite, PcWrite, PcSel};

    function automatic vec_t mk(string name, logic [5:0] op, logic [5:0] fn, logic zero,
                                logic dmr, logic [2:0] st, logic [6:0] strb, logic [2:0] br,
                                logic flt, int cnt);
        vec_t v;
        v.name = name; v.op = op; v.fn = fn; v.zero = zero; v.dmr = dmr;
        v.st = st; v.strb = strb; v.br = br; v.flt = flt; v.cnt = cnt;
        return v;
    endfunction

    task automatic expect_out(string tag, logic [2:0] st, logic [6:0] strb, logic [2:0] br,
                              logic flt, int cnt);
        checks++;
        if ({State, act_strb, Branch, Fault} !== {st, strb, br, flt}) begin
            errors++;
            $display("FAIL %s: got state=%0d strobes=%b branch=%b fault=%b, want state=%0d strobes=%b branch=%b fault=%b",
                     tag, State, act_strb, Branch, Fault, st, strb, br, flt);
        end
        checks++;
        if (InstrCnt !== CNT_W'(cnt)) begin
            errors++;
            $display("FAIL %s instr_cnt: got %0d want %0d", tag, InstrCnt, cnt);
        end
    endtask

    task automatic expect_int(string tag, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then let outputs settle.
    task automatic apply(logic [5:0] op, logic [5:0] fn, logic z, logic imr, logic dmr);
        @(negedge Clk);
        Opcode = op; Funct = fn; Zero = z; IMemReady = imr; DMemReady = dmr;
        #1;
        n_cyc++;
        if (PcWrite) n_pcw++;
        if (DMemReq) n_dmq++;
        if (DMemWe)  n_dmw++;
    endtask

    task automatic do_reset(string tag);
        @(negedge Clk);
        ReSet_n = 1'b0;
        Opcode = '0; Funct = '0; Zero = 1'b0; IMemReady = 1'b0; DMemReady = 1'b0;
        @(negedge Clk);
        ReSet_n = 1'b1;
        #1;
        expect_out({tag, " reset"}, ST_I, X_NONE, 3'b000, 1'b0, 0);
        n_pcw = 0; n_dmq = 0; n_dmw = 0; n_cyc = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back(mk("addiu F", OP_ADDIU, 6'h00, 0, 0, ST_F, X_IMQ | X_IRW, 3'b000, 0, 0));
        vecs.push_back(mk("addiu D", OP_ADDIU, 6'h00, 0, 1, ST_D, X_NONE, 3'b000, 0, 0));
        vecs.push_back(mk("addiu E", OP_ADDIU, 6'h00, 0, 0, ST_E, X_NONE, 3'b000, 0, 0));
        vecs.push_back(mk("addiu W", OP_ADDIU, 6'h00, 0, 0, ST_W, X_RW | X_PCW, 3'b000, 0, 0));
        vecs.push_back(mk("beq1 F",  OP_BEQ,   6'h00, 0, 0, ST_F, X_IMQ | X_IRW, 3'b000, 0, 1));
        vecs.push_back(mk("beq1 D",  OP_BEQ,   6'h00, 1, 0, ST_D, X_NONE, 3'b000, 0, 1));
        vecs.push_back(mk("beq1 E",  OP_BEQ,   6'h00, 1, 0, ST_E, X_PCW | X_PS, 3'b000, 0, 1));
        vecs.push_back(mk("beq0 F",  OP_BEQ,   6'h00, 0, 0, ST_F, X_IMQ | X_IRW, 3'b000, 0, 2));
        vecs.push_back(mk("beq0 D",  OP_BEQ,   6'h00, 0, 0, ST_D, X_NONE, 3'b000, 0, 2));
        vecs.push_back(mk("beq0 E",  OP_BEQ,   6'h00, 0, 0, ST_E, X_PCW, 3'b000, 0, 2));
        vecs.push_back(mk("j F",     OP_J,     6'h00, 0, 0, ST_F, X_IMQ | X_IRW, 3'b000, 0, 3));
        vecs.push_back(mk("j D",     OP_J,     6'h00, 0, 0, ST_D, X_NONE, 3'b000, 0, 3));
        vecs.push_back(mk("j E",     OP_J,     6'h00, 0, 0, ST_E, X_PCW, 3'b011, 0, 3));
        vecs.push_back(mk("jr F",    OP_R,     6'h08, 0, 0, ST_F, X_IMQ | X_IRW, 3'b000, 0, 4));
        vecs.push_back(mk("jr D",    OP_R,     6'h08, 0, 0, ST_D, X_NONE, 3'b000, 0, 4));
        vecs.push_back(mk("jr E",    OP_R,     6'h08, 0, 0, ST_E, X_PCW, 3'b111, 0, 4));
        vecs.push_back(mk("jal F",   OP_JAL,   6'h00, 0, 0, ST_F, X_IMQ | X_IRW, 3'b000, 0, 5));
        vecs.push_back(mk("jal D",   OP_JAL,   6'h00, 0, 0, ST_D, X_NONE, 3'b000, 0, 5));
        vecs.push_back(mk("jal E",   OP_JAL,   6'h00, 0, 0, ST_E, X_NONE, 3'b000, 0, 5));
        vecs.push_back(mk("jal W",   OP_JAL,   6'h00, 0, 0, ST_W, X_RW | X_PCW, 3'b011, 0, 5));
        vecs.push_back(mk("sw F",    OP_SW,    6'h00, 0, 0, ST_F, X_IMQ | X_IRW, 3'b000, 0, 6));
        vecs.push_back(mk("sw D",    OP_SW,    6'h00, 0, 0, ST_D, X_NONE, 3'b000, 0, 6));
        vecs.push_back(mk("sw E",    OP_SW,    6'h00, 0, 0, ST_E, X_NONE, 3'b000, 0, 6));
        vecs.push_back(mk("sw M",    OP_SW,    6'h00, 0, 1, ST_M, X_DMQ | X_DMW | X_PCW, 3'b000, 0, 6));
        vecs.push_back(mk("add F",   OP_R,     6'h20, 0, 0, ST_F, X_IMQ | X_IRW, 3'b000, 0, 7));
        vecs.push_back(mk("add D",   OP_R,     6'h20, 0, 0, ST_D, X_NONE, 3'b000, 0, 7));
        vecs.push_back(mk("add E",   OP_R,     6'h20, 1, 0, ST_E, X_NONE, 3'b000, 0, 7));
        vecs.push_back(mk("add W",   OP_R,     6'h20, 0, 0, ST_W, X_RW | X_PCW, 3'b000, 0, 7));
        vecs.push_back(mk("ill F",   OP_BAD,   6'h00, 0, 0, ST_F, X_IMQ | X_IRW, 3'b000, 0, 8));
        vecs.push_back(mk("ill D",   OP_BAD,   6'h00, 0, 0, ST_D, X_NONE, 3'b000, 0, 8));
`ifdef PC_SEQ_ILLEGAL_TRAP_EN
        vecs.push_back(mk("ill E",   OP_BAD,   6'h00, 0, 0, ST_E, X_NONE, 3'b000, 0, 8));
        vecs.push_back(mk("ill H1",  OP_ADDIU, 6'h00, 0, 0, ST_H, X_NONE, 3'b000, 1, 8));
        vecs.push_back(mk("ill H2",  OP_ADDIU, 6'h00, 0, 1, ST_H, X_NONE, 3'b000, 1, 8));
`else
        vecs.push_back(mk("ill E",   OP_BAD,   6'h00, 0, 0, ST_E, X_PCW, 3'b000, 0, 8));
        vecs.push_back(mk("nxt F",   OP_ADDIU, 6'h00, 0, 0, ST_F, X_IMQ | X_IRW, 3'b000, 0, 9));
        vecs.push_back(mk("nxt D",   OP_ADDIU, 6'h00, 0, 0, ST_D, X_NONE, 3'b000, 0, 9));
`endif

        // Main instruction mix, IMemReady held high throughout.
        do_reset("table");
        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].fn, vecs[i].zero, 1'b1, vecs[i].dmr);
            expect_out(vecs[i].name, vecs[i].st, vecs[i].strb, vecs[i].br, vecs[i].flt, vecs[i].cnt);
            $display("row %0d %s state=%0d cnt=%0d", i, vecs[i].name, State, InstrCnt);
        end

        // lw with data ready three cycles late.
        do_reset("lw");
        apply(OP_LW, 6'h00, 0, 1, 0);
        apply(OP_LW, 6'h00, 0, 1, 0);
        apply(OP_LW, 6'h00, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            apply(OP_LW, 6'h00, 0, 1, (i == 3));
            expect_out($sformatf("lw M%0d", i), ST_M, X_DMQ, 3'b000, 0, 0);
        end
        apply(OP_LW, 6'h00, 0, 1, 0);
        expect_out("lw W", ST_W, X_RW | X_PCW, 3'b000, 0, 0);
        expect_int("lw total cycles", n_cyc, 9);
        expect_int("lw dmemreq cycles", n_dmq, 4);
        expect_int("lw dmemwe cycles", n_dmw, 0);
        expect_int("lw pcwrite pulses", n_pcw, 1);
        apply(OP_LW, 6'h00, 0, 1, 0);
        expect_out("lw next F", ST_F, X_IMQ | X_IRW, 3'b000, 0, 1);
        $display("seq lw-delay done cycles=%0d", n_cyc);

        // Instruction memory never ready: halt after 16 wait cycles.
        do_reset("tmo");
        for (int i = 0; i < 16; i++) begin
            apply(OP_ADDIU, 6'h00, 0, 0, 0);
            expect_out($sformatf("tmo wait%0d", i), ST_F, X_IMQ, 3'b000, 0, 0);
        end
        apply(OP_ADDIU, 6'h00, 0, 1, 1);
        expect_out("tmo halt", ST_H, X_NONE, 3'b000, 1, 0);
        apply(OP_ADDIU, 6'h00, 0, 1, 1);
        expect_out("tmo halt held", ST_H, X_NONE, 3'b000, 1, 0);
        expect_int("tmo pcwrite pulses", n_pcw, 0);
        $display("seq timeout done state=%0d fault=%b", State, Fault);

        // Ready arrives on the 16th wait cycle: no fault.
        do_reset("rdy16");
        for (int i = 0; i < 15; i++)
            apply(OP_ADDIU, 6'h00, 0, 0, 0);
        apply(OP_ADDIU, 6'h00, 0, 1, 0);
        expect_out("rdy16 F", ST_F, X_IMQ | X_IRW, 3'b000, 0, 0);
        apply(OP_ADDIU, 6'h00, 0, 1, 0);
        expect_out("rdy16 D", ST_D, X_NONE, 3'b000, 0, 0);
        $display("seq ready-at-limit done state=%0d fault=%b", State, Fault);

        // Async reset during the MEM wait of a sw, after one retired j.
        do_reset("rst");
        apply(OP_J, 6'h00, 0, 1, 0);
        apply(OP_J, 6'h00, 0, 1, 0);
        apply(OP_J, 6'h00, 0, 1, 0);
        apply(OP_SW, 6'h00, 0, 1, 0);
        apply(OP_SW, 6'h00, 0, 1, 0);
        apply(OP_SW, 6'h00, 0, 1, 0);
        apply(OP_SW, 6'h00, 0, 1, 0);
        expect_out("rst sw M", ST_M, X_DMQ | X_DMW, 3'b000, 0, 1);
        n_dmw = 0; n_pcw = 0;
        #1 ReSet_n = 1'b0;
        #1;
        expect_out("rst abort", ST_I, X_NONE, 3'b000, 0, 0);
        apply(OP_SW, 6'h00, 0, 1, 1);
        expect_out("rst held", ST_I, X_NONE, 3'b000, 0, 0);
        @(negedge Clk);
        ReSet_n = 1'b1;
        apply(OP_SW, 6'h00, 0, 1, 1);
        expect_out("rst restart F", ST_F, X_IMQ | X_IRW, 3'b000, 0, 0);
        expect_int("rst dmemwe after abort", n_dmw, 0);
        expect_int("rst pcwrite after abort", n_pcw, 0);
        $display("seq reset-abort done state=%0d", State);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
